// File: rtl/spi_pkg.sv
// Types and command codes shared by the SPI slave front end and the RAM it feeds.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: loads one read byte per frame and shifts it out MSB first.
module spi_tx_shifter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] data,
  output logic                 MISO,
  output logic                 busy
);

  localparam int CW = $clog2(ADDR_SIZE + 1);

  logic [ADDR_SIZE-1:0] shift_q;
  logic [CW-1:0]        cnt_q;
  logic                 tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      tx_done_q <= 1'b0;
      busy      <= 1'b0;
      MISO      <= 1'b0;
    end else if (abort) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      tx_done_q <= 1'b0;
      busy      <= 1'b0;
      MISO      <= 1'b0;
    end else if (load && !tx_done_q) begin
      // MSB goes out immediately; the shifter keeps only the bits still owed
      shift_q   <= data << 1;
      MISO      <= data[ADDR_SIZE-1];
      cnt_q     <= CW'(ADDR_SIZE - 1);
      busy      <= 1'b1;
      tx_done_q <= 1'b1;
    end else if (busy) begin
      if (cnt_q != '0) begin
        MISO    <= shift_q[ADDR_SIZE-1];
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q - 1'b1;
      end else begin
        MISO <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: frames MOSI into command words for the RAM and returns
// the RAM read byte on MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid
);

  localparam int FW    = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(FW) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FW);

  spi_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FW-2:0]     rx_shift_q;
  logic [FW-1:0]     rx_data_q;
  logic              rx_valid_q;
  logic              rd_addr_seen_q;
  logic [FW-1:0]     word_d;
  logic              tx_load;
  logic              tx_busy;

  assign word_d = {rx_shift_q, MOSI};

  // Transmit only once a read-data frame has fully arrived
  assign tx_load = !SS_n && (state_q == READ_DATA) && (cnt_q == CNT_DONE) &&
                   (rx_data_q[FW-1 -: 2] == CMD_RD_DATA) && tx_valid && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CHK_CMD;
            cnt_q   <= '0;
          end
          CHK_CMD: begin
            rx_shift_q <= {rx_shift_q[FW-3:0], MOSI};
            cnt_q      <= CNT_W'(1);
            if (!MOSI)               state_q <= WRITE;
            else if (rd_addr_seen_q) state_q <= READ_DATA;
            else                     state_q <= READ_ADD;
          end
          default: begin
            // Counter saturates at CNT_DONE so trailing bits are ignored
            if (cnt_q != CNT_DONE) begin
              rx_shift_q <= {rx_shift_q[FW-3:0], MOSI};
              cnt_q      <= cnt_q + 1'b1;
              if (cnt_q == CNT_LAST) begin
                rx_data_q  <= word_d;
                rx_valid_q <= 1'b1;
                if (word_d[FW-1 -: 2] == CMD_RD_ADDR)      rd_addr_seen_q <= 1'b1;
                else if (word_d[FW-1 -: 2] == CMD_RD_DATA) rd_addr_seen_q <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .ADDR_SIZE(ADDR_SIZE)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tx_load),
    .abort(SS_n),
    .data (tx_data),
    .MISO (MISO),
    .busy (tx_busy)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: frame decode, read transmit, aborts and reset.
module tb_spi_slave_if;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drops SS_n and sends the first nbits of w MSB first.
  task automatic send_frame(input logic [9:0] w, input int nbits,
                            output int pulses, output int miso_ones);
    pulses = 0;
    miso_ones = 0;
    SS_n = 1'b0;
    @(negedge clk);
    pulses += int'(rx_valid);
    miso_ones += int'(MISO);
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[9-i];
      @(negedge clk);
      pulses += int'(rx_valid);
      miso_ones += int'(MISO);
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p;
    int m;
    logic [8:0] seq;
    logic [2:0] seq3;

    #2;
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read-data command with no prior read-address goes to READ_ADD
    send_frame(10'h300, 10, p, m);
    $display("[TB] frame 300 (no rd addr): rx_data=%h state=%0d", rx_data, dut.state_q);
    check("rdnoaddr_state", 32'(dut.state_q), 32'(READ_ADD));
    check("rdnoaddr_rx_data", 32'(rx_data), 32'h300);
    check("rdnoaddr_pulses", 32'(p), 32'd1);
    check("rdnoaddr_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    tx_data = 8'hA7;
    tx_valid = 1'b1;
    m = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m += int'(MISO);
    end
    tx_valid = 1'b0;
    check("rdnoaddr_miso_quiet", 32'(m), 32'd0);
    end_frame();

    // Write address
    send_frame(10'h025, 10, p, m);
    $display("[TB] frame 025: rx_data=%h rx_valid=%b", rx_data, rx_valid);
    check("wraddr_rx_valid", 32'(rx_valid), 32'd1);
    check("wraddr_rx_data", 32'(rx_data), 32'h025);
    check("wraddr_pulses", 32'(p), 32'd1);
    check("wraddr_miso", 32'(m), 32'd0);
    @(negedge clk);
    check("wraddr_valid_drop", 32'(rx_valid), 32'd0);
    end_frame();

    // Write data
    send_frame(10'h1A7, 10, p, m);
    $display("[TB] frame 1A7: rx_data=%h", rx_data);
    check("wrdata_rx_data", 32'(rx_data), 32'h1A7);
    check("wrdata_pulses", 32'(p), 32'd1);
    check("wrdata_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    end_frame();

    // Read address then read data with transmit
    send_frame(10'h225, 10, p, m);
    $display("[TB] frame 225: rx_data=%h", rx_data);
    check("rdaddr_rx_data", 32'(rx_data), 32'h225);
    check("rdaddr_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    end_frame();
    send_frame(10'h300, 10, p, m);
    $display("[TB] frame 300: rx_data=%h state=%0d", rx_data, dut.state_q);
    check("rddata_state", 32'(dut.state_q), 32'(READ_DATA));
    check("rddata_rx_data", 32'(rx_data), 32'h300);
    check("rddata_pulses", 32'(p), 32'd1);
    check("rddata_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    @(negedge clk);
    check("rddata_miso_pre", 32'(MISO), 32'd0);
    tx_data = 8'hA7;
    tx_valid = 1'b1;
    seq = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      seq = {seq[7:0], MISO};
    end
    $display("[TB] MISO stream: %b", seq);
    check("rddata_miso_seq", 32'(seq), 32'(9'b101001110));
    m = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m += int'(MISO);
    end
    tx_valid = 1'b0;
    check("rddata_no_retx", 32'(m), 32'd0);
    end_frame();

    // Frame aborted after 5 bits
    send_frame(10'h3FF, 5, p, m);
    end_frame();
    $display("[TB] aborted frame: state=%0d rx_data=%h", dut.state_q, rx_data);
    check("abort_pulses", 32'(p), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_rx_data_hold", 32'(rx_data), 32'h300);
    send_frame(10'h010, 10, p, m);
    $display("[TB] frame 010: rx_data=%h", rx_data);
    check("after_abort_rx_data", 32'(rx_data), 32'h010);
    check("after_abort_pulses", 32'(p), 32'd1);
    end_frame();

    // Abort in the middle of a transmit
    send_frame(10'h225, 10, p, m);
    end_frame();
    send_frame(10'h300, 10, p, m);
    @(negedge clk);
    tx_data = 8'hA7;
    tx_valid = 1'b1;
    seq3 = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seq3 = {seq3[1:0], MISO};
    end
    check("txabort_first_bits", 32'(seq3), 32'(3'b101));
    SS_n = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    $display("[TB] transmit abort: MISO=%b state=%0d", MISO, dut.state_q);
    check("txabort_miso", 32'(MISO), 32'd0);
    check("txabort_state", 32'(dut.state_q), 32'(IDLE));

    // Asynchronous reset in the middle of a frame
    send_frame(10'h2AB, 10, p, m);
    check("prereset_rx_data", 32'(rx_data), 32'h2AB);
    end_frame();
    send_frame(10'h3C3, 4, p, m);
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset: rx_data=%h rx_valid=%b MISO=%b", rx_data, rx_valid, MISO);
    check("areset_rx_data", 32'(rx_data), 32'd0);
    check("areset_rx_valid", 32'(rx_valid), 32'd0);
    check("areset_miso", 32'(MISO), 32'd0);
    check("areset_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    check("areset_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    SS_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that deserialises MOSI frames into 10-bit command words for the single-port RAM. The RAM receives them through its `din`/`rx_valid` inputs.
- Serialises the RAM read byte (`dout`/`tx_valid`) back out on MISO.
- Sits directly upstream/downstream of the RAM inside the SPI wrapper.
- SPI bit clock is the system clock `clk`: one MOSI/MISO bit per `clk` posedge while `SS_n` is low.

Parameters:
- ADDR_SIZE, 8, RAM address/data width. Frame width is ADDR_SIZE+2 (2 command bits + payload).

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select, active low; frames bounded by `SS_n` low.
- MOSI  input  1  serial data in, MSB first.
- tx_data  input  ADDR_SIZE  read byte from the RAM (`dout`).
- tx_valid  input  1  RAM read-data valid. May stay high for several cycles.
- MISO  output  1  serial data out, MSB first, registered.
- rx_data  output  ADDR_SIZE+2  command word to the RAM (`din`); `[ADDR_SIZE+1:ADDR_SIZE]` = command.
- rx_valid  output  1  one-cycle strobe: `rx_data` complete.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE, `MISO`=0, `rx_data`=0, `rx_valid`=0, bit counter=0, rd_addr_seen=0, tx_done=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - Outputs idle.
  - Posedge T0 with `SS_n`=0 → CHK_CMD. No bit captured at T0.
- CHK_CMD (T1):
  - Samples MOSI as frame bit `[ADDR_SIZE+1]`.
  - 0 → WRITE.
  - 1 and rd_addr_seen=0 → READ_ADD.
  - 1 and rd_addr_seen=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA (receive):
  - Shift the remaining ADDR_SIZE+1 bits on T2..T(ADDR_SIZE+2), MSB first.
  - At the edge that captures the last bit (T10 for default), `rx_data` is loaded with the full word and `rx_valid`=1 for exactly one cycle.
  - `rx_data` holds until the next completed frame.
- Command bookkeeping on completed frame:
  - cmd=2'b10 sets rd_addr_seen.
  - cmd=2'b11 clears it.
  - cmd=2'b00/01 leave it unchanged.
  - `rx_data` is forwarded verbatim even if the command bit `[ADDR_SIZE]` disagrees with the state; the RAM decodes.
- Bits after the last frame bit in WRITE/READ_ADD are ignored until `SS_n` rises.
- READ_DATA transmit:
  - Starts after the frame completes with cmd=11 and tx_done=0.
  - First posedge with `tx_valid`=1 latches `tx_data` into the shift register, drives `MISO`=`tx_data[ADDR_SIZE-1]`, and sets tx_done.
  - Next ADDR_SIZE-1 edges shift out the remaining bits. After the LSB cycle, `MISO`=0.
  - Further `tx_valid` cycles in the same frame are ignored (tx_done=1).
- `MISO`=0 whenever not transmitting.
- Nominal read-data latency (default):
  - rx_valid at T10.
  - RAM `tx_valid` visible at T12.
  - MISO bit7 valid T12..T13, LSB at T19..T20.
- `SS_n` high at any posedge:
  - Next state IDLE; partial frame discarded, no `rx_valid`.
  - Transmit aborted, `MISO`=0, counter and tx_done cleared.
  - rd_addr_seen retained.
- `SS_n` low held across frames without a rising edge is one frame only. A new frame requires a return to IDLE.
- `rx_valid` and the transmit start never coincide in the same cycle, by construction of the latency above.
- Reset mid-frame: immediate return to reset values. The RAM is reset by the same `rst_n`.
- Bit counter width: `$clog2(ADDR_SIZE+2)+1`. No wrap inside a frame; it saturates at the frame end until IDLE.

Decomposition:
- Package spi_pkg:
  - state enum `spi_state_e`.
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - shared by this block and the RAM.
- Sub-module spi_tx_shifter:
  - ADDR_SIZE-bit load/shift register plus bit counter and tx_done.
  - Ports: clk, rst_n, load, abort, data, MISO, busy.
- FSM and receive shifter stay in spi_slave_if.

Test Plan:
- Write address: SS_n low, MOSI 0,0,0x25 MSB first → `rx_valid` one cycle at T10, `rx_data`=10'h025, `MISO`=0 throughout.
- Write data: frame 0,1,0xA7 → `rx_data`=10'h1A7, one `rx_valid` pulse; rd_addr_seen unchanged (0).
- Read sequence: frame 1,0,0x25 (rd_addr_seen→1), SS_n high, then frame 1,1,0x00 with `tx_valid` held high 9 cycles and `tx_data`=0xA7 → state READ_DATA, `rx_data`=10'h300, MISO emits 1,0,1,0,0,1,1,1 exactly once, then 0; rd_addr_seen→0.
- Abort: SS_n rises after 5 bits of a frame → no `rx_valid`, state IDLE next cycle; the following full frame 0,0,0x10 decodes as 10'h010.
- Mid-transmit abort and reset: SS_n rises after 3 MISO bits → `MISO`=0 next cycle. `rst_n` low mid-frame → all outputs 0 asynchronously and rd_addr_seen cleared.
- Read-data without prior read-address: first frame 1,1,0x00 after reset → state READ_ADD chosen (rd_addr_seen=0), `rx_data`=10'h300 forwarded, rd_addr_seen stays 0.
